cic_integrator_decim: RTL and testbench

Integrator and decimation front end of the CIC decimating filter. Runs a cascade of STAGES integrators at the input sample rate. Once per R input samples it hands the last integrator's value to the comb chain as one sample plus a single-cycle strobe, where R is selectable at run time. Sits directly upstream of the cic_comb stages; its out_strobe/out_data drive the first comb's strobe/in_data.

---
 rtl/cic_pkg.sv | 27 ++
 rtl/cic_integrator.sv | 45 ++++
 rtl/cic_integrator_decim.sv | 97 +++++++++
 tb/tb_cic_integrator_decim.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// ============================================================================
//  Module      : cic_pkg
//  Description : Shared constants and helpers for the CIC decimator blocks.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package cic_pkg;

    localparam int unsigned c_min_rate = 2;

    // Minimum accumulator width that keeps CIC wrap-around arithmetic exact.
    function automatic int unsigned cic_min_width(
        input int unsigned in_w,
        input int unsigned stages,
        input int unsigned rate_w
    );
        return in_w + stages * rate_w;
    endfunction

    function automatic logic [31:0] clamp_rate(input logic [31:0] r);
        return (r < c_min_rate) ? 32'(c_min_rate) : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cic_integrator.sv
// ============================================================================
//  Module      : cic_integrator
//  Description : One wrapping accumulator stage of the CIC integrator chain.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module cic_integrator
    import cic_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             strobe,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (strobe) begin
            acc_d = acc_q + in_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out_data = acc_q;

endmodule

`default_nettype wire

// File: rtl/cic_integrator_decim.sv
// ============================================================================
//  Module      : cic_integrator_decim
//  Description : CIC integrator cascade with run-time selectable decimation.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module cic_integrator_decim
    import cic_pkg::*;
#(
    parameter int STAGES     = 5,
    parameter int IN_WIDTH   = 24,
    parameter int WIDTH      = 64,
    parameter int RATE_WIDTH = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        in_strobe,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic [RATE_WIDTH-1:0]       rate,
    output logic                        out_strobe,
    output logic signed [WIDTH-1:0]     out_data
);

    if ((WIDTH < cic_min_width(IN_WIDTH, STAGES, RATE_WIDTH)) || (RATE_WIDTH < 2)
            || (STAGES < 1) || (STAGES > 8)) begin : g_param_check
        $error("cic_integrator_decim: illegal parameter combination");
    end

    logic [WIDTH-1:0]      w_chain [STAGES+1];
    logic [RATE_WIDTH-1:0] w_rate_clamped;
    logic                  w_event;

    logic [RATE_WIDTH-1:0] cnt_q,      cnt_d;
    logic [RATE_WIDTH-1:0] rate_q,     rate_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic                  out_strobe_q, out_strobe_d;

    assign w_chain[0] = WIDTH'(in_data);

    // Stage k adds the registered (pre-update) value of stage k-1.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        cic_integrator #(
            .WIDTH (WIDTH)
        ) u_integ (
            .clock    (clock),
            .reset_n  (reset_n),
            .clear    (clear),
            .strobe   (in_strobe),
            .in_data  (w_chain[gi]),
            .out_data (w_chain[gi+1])
        );
    end

    assign w_rate_clamped = RATE_WIDTH'(clamp_rate(32'(rate)));
    assign w_event        = in_strobe && !clear && (cnt_q == (rate_q - RATE_WIDTH'(1)));

    always_comb begin
        cnt_d        = cnt_q;
        rate_d       = rate_q;
        out_data_d   = out_data_q;
        out_strobe_d = 1'b0;
        if (clear) begin
            cnt_d      = '0;
            rate_d     = w_rate_clamped;
            out_data_d = '0;
        end else if (w_event) begin
            cnt_d        = '0;
            rate_d       = w_rate_clamped;
            out_data_d   = w_chain[STAGES];
            out_strobe_d = 1'b1;
        end else if (in_strobe) begin
            cnt_d = cnt_q + RATE_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            rate_q       <= RATE_WIDTH'(c_min_rate);
            out_data_q   <= '0;
            out_strobe_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            rate_q       <= rate_d;
            out_data_q   <= out_data_d;
            out_strobe_q <= out_strobe_d;
        end
    end

    assign out_strobe = out_strobe_q;
    assign out_data   = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_cic_integrator_decim.sv
// ============================================================================
//  Module      : tb_cic_integrator_decim
//  Description : Scoreboard bench for the CIC integrator/decimator front end.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cic_integrator_decim;

    localparam int STAGES     = 5;
    localparam int IN_WIDTH   = 24;
    localparam int WIDTH      = 64;
    localparam int RATE_WIDTH = 8;

    logic                       clock     = 1'b0;
    logic                       reset_n   = 1'b0;
    logic                       clear     = 1'b0;
    logic                       in_strobe = 1'b0;
    logic signed [IN_WIDTH-1:0] in_data   = '0;
    logic [RATE_WIDTH-1:0]      rate      = 8'd2;
    logic                       out_strobe;
    logic signed [WIDTH-1:0]    out_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0]      sb_q [$];
    logic [WIDTH-1:0]      cap  [$];
    bit                    capture = 1'b0;

    logic [WIDTH-1:0]      m_integ [STAGES];
    logic [RATE_WIDTH-1:0] m_cnt;
    logic [RATE_WIDTH-1:0] m_rate;
    logic                  m_strobe;
    logic [WIDTH-1:0]      m_out;

    cic_integrator_decim #(
        .STAGES     (STAGES),
        .IN_WIDTH   (IN_WIDTH),
        .WIDTH      (WIDTH),
        .RATE_WIDTH (RATE_WIDTH)
    ) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .in_strobe  (in_strobe),
        .in_data    (in_data),
        .rate       (rate),
        .out_strobe (out_strobe),
        .out_data   (out_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [RATE_WIDTH-1:0] m_clamp(input logic [RATE_WIDTH-1:0] r);
        return (r < 2) ? RATE_WIDTH'(2) : r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < STAGES; k++) m_integ[k] = '0;
        m_cnt    = '0;
        m_rate   = RATE_WIDTH'(2);
        m_strobe = 1'b0;
        m_out    = '0;
        sb_q.delete();
    endtask

    // Reference behaviour for one clock edge given the inputs about to be sampled.
    task automatic model_step(input bit s, input logic signed [IN_WIDTH-1:0] d, input bit c);
        m_strobe = 1'b0;
        if (c) begin
            for (int k = 0; k < STAGES; k++) m_integ[k] = '0;
            m_cnt  = '0;
            m_out  = '0;
            m_rate = m_clamp(rate);
        end else if (s) begin
            if (m_cnt == m_rate - 8'd1) begin
                m_out    = m_integ[STAGES-1];
                sb_q.push_back(m_integ[STAGES-1]);
                m_cnt    = '0;
                m_rate   = m_clamp(rate);
                m_strobe = 1'b1;
            end else begin
                m_cnt = m_cnt + 8'd1;
            end
            for (int k = STAGES - 1; k > 0; k--) m_integ[k] = m_integ[k] + m_integ[k-1];
            m_integ[0] = m_integ[0] + WIDTH'(d);
        end
    endtask

    task automatic cycle(input bit s, input logic signed [IN_WIDTH-1:0] d, input bit c);
        logic [WIDTH-1:0] exp;
        in_strobe = s;
        in_data   = d;
        clear     = c;
        model_step(s, d, c);
        @(posedge clock);
        #1;
        in_strobe = 1'b0;
        clear     = 1'b0;
        chk("out_strobe", WIDTH'(out_strobe), WIDTH'(m_strobe));
        if (out_strobe) begin
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", WIDTH'(1), WIDTH'(0));
            end else begin
                exp = sb_q.pop_front();
                chk("out_data", out_data, exp);
                if (capture) cap.push_back(out_data);
            end
        end
    endtask

    initial begin
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] exp_dc;

        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_strobe", WIDTH'(out_strobe), WIDTH'(0));
        chk("reset_data", out_data, '0);
        reset_n = 1'b1;

        // DC input of 1 at R=4
        rate = 8'd4;
        for (int i = 0; i < 20; i++) cycle(1'b1, 24'sd1, 1'b0);

        // Impulse after a flush
        cycle(1'b0, 24'sd0, 1'b1);
        cycle(1'b1, 24'sd1, 1'b0);
        for (int i = 0; i < 24; i++) cycle(1'b1, 24'sd0, 1'b0);

        // Rate change 4 -> 8 mid-stream, with gaps in the strobe
        for (int i = 0; i < 6; i++) cycle(1'b1, 24'(signed'($urandom_range(0, 1000))), 1'b0);
        rate = 8'd8;
        for (int i = 0; i < 40; i++)
            cycle($urandom_range(0, 3) != 0, 24'(signed'($urandom_range(0, 1000))), 1'b0);

        // Rates 0 and 1 behave as 2
        rate = 8'd0;
        for (int i = 0; i < 12; i++) cycle(1'b1, 24'($urandom), 1'b0);
        rate = 8'd1;
        for (int i = 0; i < 12; i++) cycle($urandom_range(0, 1) != 0, 24'($urandom), 1'b0);
        rate = 8'd2;
        for (int i = 0; i < 8; i++) cycle(1'b1, -24'sd3, 1'b0);

        // Clear together with a strobe discards that sample
        rate = 8'd3;
        cycle(1'b1, 24'sd77, 1'b1);
        chk("clear_data", out_data, '0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 24'sd5, 1'b0);

        // Asynchronous reset mid-period
        cycle(1'b1, 24'sd9, 1'b0);
        cycle(1'b1, 24'sd9, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_strobe", WIDTH'(out_strobe), WIDTH'(0));
        chk("async_rst_data", out_data, '0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        rate    = 8'd6;
        for (int i = 0; i < 16; i++) cycle(1'b1, 24'sd2, 1'b0);

        // Full-scale negative DC at R=255: integrators wrap, combs must recover it
        rate = 8'd255;
        cycle(1'b0, 24'sd0, 1'b1);
        capture = 1'b1;
        for (int i = 0; i < 14 * 255 + 1; i++) cycle(1'b1, 24'sh800000, 1'b0);
        capture = 1'b0;
        chk("wrap_output_count", WIDTH'(cap.size() >= 12), WIDTH'(1));
        exp_dc = (~64'd8388608 + 64'd1) * 64'd1078203909375;
        for (int i = 6; i < cap.size(); i++) begin
            y = cap[i] - 64'd5 * cap[i-1] + 64'd10 * cap[i-2]
              - 64'd10 * cap[i-3] + 64'd5 * cap[i-4] - cap[i-5];
            chk("comb_dc_gain", y, exp_dc);
        end
        chk("scoreboard_drained", WIDTH'(sb_q.size()), WIDTH'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
